uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of byte-stream requesters sharing the UART transmit path.
REQ-002 SHALL have parameter UartDataWidth, default 8, byte width per requester.
REQ-003 SHALL have parameter BusDataWidth, default 32, width of the UART register-bus address and data.
REQ-004 SHALL have parameter FifoDepth, default 16, UART transmit FIFO depth and the initial credit count.
REQ-005 SHALL have parameter BaudSel, default 2'b00, baud select written once after reset.
REQ-006 SHALL have parameter TimeoutCycles, default 1024, idle-lock timeout used only under the timeout macro.
REQ-007 SHALL have ports clk_i, input, 1, sole clock; and rst_i, input, 1, reset. Both are fixed as one clock with reset synchronous and active-high.
REQ-008 SHALL have port req_valid_i, input, NumReq, per-requester byte valid.
REQ-009 SHALL have port req_data_i, input, NumReq*UartDataWidth, with requester k occupying slice [k*UartDataWidth +: UartDataWidth].
REQ-010 SHALL have port req_last_i, input, NumReq, marking the final byte of a packet.
REQ-011 SHALL have port req_ready_o, output, NumReq, per-requester accept.
REQ-012 SHALL have port tx_done_i, input, 1, one-cycle pulse each time the UART transmitter finishes a byte.
REQ-013 SHALL have ports bus_wr_en_o, output, 1; bus_addr_o, output, BusDataWidth; and bus_wdata_o, output, BusDataWidth. These form the write port into the UART register bus.
REQ-014 SHALL have port grant_o, output, NumReq, one-hot owner of the transmit path, or all zeros.
REQ-015 SHALL have port credits_o, output, $clog2(FifoDepth+1), free UART TX FIFO slots.
REQ-016 SHALL have port timeout_o, output, 1, one-cycle pulse on a forced lock release.

Function
REQ-017 SHALL implement FSM states INIT, IDLE and XFER.
REQ-018 INIT SHALL last exactly one cycle with bus_wr_en_o=1, bus_addr_o=0 and bus_wdata_o=BusDataWidth'(BaudSel), then go to IDLE.
REQ-019 In IDLE with credits>0 and any req_valid_i set, the FSM SHALL grant the first valid requester at or after rr_ptr (round robin, wrapping NumReq-1 to 0), register grant_o and go to XFER next cycle. No byte SHALL be accepted in the arbitration cycle.
REQ-020 In XFER, req_ready_o[g] SHALL equal (credits>0) for the granted index g; all other ready bits SHALL be 0.
REQ-021 On a handshake (valid&ready for g), the same cycle SHALL drive bus_wr_en_o=1, bus_addr_o=3 and bus_wdata_o=zero-extended req_data_i slice g (zero-cycle latency).
REQ-022 A handshake with req_last_i[g]=1 SHALL return the FSM to IDLE, clear grant_o and set rr_ptr=(g+1) mod NumReq.
REQ-023 Grant SHALL be locked for the whole packet; other requesters SHALL wait even when g is stalled.
REQ-024 Credits SHALL decrement on a handshake and increment on tx_done_i; simultaneous events SHALL leave them unchanged.
REQ-025 tx_done_i arriving at credits==FifoDepth SHALL be ignored (saturate).
REQ-026 When credits==0, no ready SHALL be asserted and IDLE SHALL not arbitrate.
REQ-027 bus_wr_en_o SHALL be 0 in every cycle without an INIT or handshake write, and bus_addr_o/bus_wdata_o SHALL be 0 in those cycles.
REQ-028 Requesters SHALL hold data and last stable while valid&!ready; the block SHALL not latch data.

Reset
REQ-029 rst_i high at a clock edge SHALL set state=INIT, credits=FifoDepth, rr_ptr=0, grant_o=0, timeout counter=0 and timeout_o=0, including mid-packet; a partially sent packet SHALL be abandoned.
REQ-030 During reset all req_ready_o and bus_wr_en_o SHALL be 0.

Configuration
REQ-031 With macro UART_TX_ARB_TIMEOUT_EN defined, in XFER a counter SHALL count cycles without a handshake and clear on each handshake.
REQ-032 Under UART_TX_ARB_TIMEOUT_EN, reaching TimeoutCycles SHALL force IDLE, clear grant_o, advance rr_ptr past g and pulse timeout_o for one cycle.
REQ-033 Without the macro, no counter SHALL exist, timeout_o SHALL be tied 0 and the lock SHALL persist indefinitely.

Verification
REQ-034 Reset release -> one cycle with bus_wr_en_o=1, addr=0, wdata=BaudSel; credits_o=16.
REQ-035 Requesters 0 and 2 each send a 3-byte packet at once -> req0 bytes at addr 3 first, then req2; no interleave; rr_ptr=1, then rr_ptr=3.
REQ-036 Req1 streams 20 bytes with no tx_done_i -> exactly 16 writes, then ready low; one tx_done_i pulse -> one more byte accepted.
REQ-037 Handshake and tx_done_i in the same cycle at credits=5 -> credits stay 5; tx_done_i at 16 -> stays 16.
REQ-038 Reset asserted mid-packet after 2 of 4 bytes -> INIT write repeats, grant_o=0, credits=16, and the next arbitration starts from req0.
REQ-039 With UART_TX_ARB_TIMEOUT_EN and TimeoutCycles=8, granted req3 drops valid -> after 8 cycles timeout_o pulses and req0 wins next; without the macro, req3 keeps the grant.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one UART transmit path between NumReq byte-stream
//             requesters. Writes the baud select once after reset, then
//             grants the path round-robin per packet. Each accepted byte is
//             written to the UART data register in the same cycle. A credit
//             counter mirrors the free slots in the UART TX FIFO.
//  Ports    : clk_i/rst_i          - clock, synchronous active-high reset
//             req_valid_i/_data_i/_last_i, req_ready_o - requester streams
//             tx_done_i            - UART finished one byte (returns a credit)
//             bus_wr_en_o/_addr_o/_wdata_o - UART register-bus write port
//             grant_o              - one-hot owner of the path (or zero)
//             credits_o            - free UART TX FIFO slots
//             timeout_o            - pulse on a forced lock release
//  Options  : UART_TX_ARB_TIMEOUT_EN - when defined, a grant with no
//             handshake for TimeoutCycles cycles is released.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int         NumReq        = 4,
    parameter int         UartDataWidth = 8,
    parameter int         BusDataWidth  = 32,
    parameter int         FifoDepth     = 16,
    parameter logic [1:0] BaudSel       = 2'b00,
    parameter int         TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    input  logic [NumReq*UartDataWidth-1:0] req_data_i,
    input  logic [NumReq-1:0]               req_last_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic                            tx_done_i,
    output logic                            bus_wr_en_o,
    output logic [BusDataWidth-1:0]         bus_addr_o,
    output logic [BusDataWidth-1:0]         bus_wdata_o,
    output logic [NumReq-1:0]               grant_o,
    output logic [$clog2(FifoDepth+1)-1:0]  credits_o,
    output logic                            timeout_o
);

    localparam int c_IDX_W  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int c_CRED_W = $clog2(FifoDepth + 1);

    localparam logic [c_CRED_W-1:0]     c_CRED_MAX = c_CRED_W'(FifoDepth);
    localparam logic [c_CRED_W-1:0]     c_CRED_ONE = c_CRED_W'(1);
    localparam logic [c_IDX_W-1:0]      c_IDX_LAST = c_IDX_W'(NumReq - 1);
    localparam logic [c_IDX_W-1:0]      c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [BusDataWidth-1:0] c_ADDR_BAUD = BusDataWidth'(0);
    localparam logic [BusDataWidth-1:0] c_ADDR_DATA = BusDataWidth'(3);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t                  r_state,   w_state_nxt;
    logic [NumReq-1:0]       r_grant,   w_grant_nxt;
    logic [c_IDX_W-1:0]      r_gidx,    w_gidx_nxt;
    logic [c_IDX_W-1:0]      r_rr_ptr,  w_rr_nxt;
    logic [c_CRED_W-1:0]     r_credits, w_credits_nxt;

    logic                     w_has_credit;
    logic                     w_ready_g;
    logic                     w_hs;
    logic                     w_hs_last;
    logic                     w_force_release;
    logic [c_IDX_W-1:0]       w_after_g;
    logic [c_IDX_W-1:0]       w_scan_idx;
    logic [c_IDX_W-1:0]       w_pick_idx;
    logic                     w_pick_found;
    logic [UartDataWidth-1:0] w_gdata;

    assign w_has_credit = (r_credits != '0);

    // Ready and handshake are qualified with !rst_i so that nothing is
    // accepted or written while reset is held, whatever the state was.
    assign w_ready_g   = (r_state == S_XFER) && w_has_credit && !rst_i;
    assign req_ready_o = w_ready_g ? r_grant : '0;
    assign w_hs        = w_ready_g && req_valid_i[r_gidx];
    assign w_hs_last   = w_hs && req_last_i[r_gidx];
    assign w_gdata     = req_data_i[int'(r_gidx)*UartDataWidth +: UartDataWidth];
    assign w_after_g   = (r_gidx == c_IDX_LAST) ? '0 : (r_gidx + c_IDX_ONE);

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_scan_idx = c_IDX_W'((int'(r_rr_ptr) + i) % NumReq);
            if (!w_pick_found && req_valid_i[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    // Bus write port: baud write in INIT, data write on a handshake,
    // otherwise all zero.
    always_comb begin
        bus_wr_en_o = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        if (!rst_i && (r_state == S_INIT)) begin
            bus_wr_en_o = 1'b1;
            bus_addr_o  = c_ADDR_BAUD;
            bus_wdata_o = BusDataWidth'(BaudSel);
        end else if (w_hs) begin
            bus_wr_en_o = 1'b1;
            bus_addr_o  = c_ADDR_DATA;
            bus_wdata_o = BusDataWidth'(w_gdata);
        end
    end

    // Credits: a handshake and a tx_done in the same cycle cancel out;
    // tx_done at a full count is dropped.
    always_comb begin
        w_credits_nxt = r_credits;
        if (w_hs && !tx_done_i) begin
            w_credits_nxt = r_credits - c_CRED_ONE;
        end else if (!w_hs && tx_done_i && (r_credits != c_CRED_MAX)) begin
            w_credits_nxt = r_credits + c_CRED_ONE;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_INIT: begin
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_has_credit && w_pick_found) begin
                    w_state_nxt             = S_XFER;
                    w_grant_nxt             = '0;
                    w_grant_nxt[w_pick_idx] = 1'b1;
                    w_gidx_nxt              = w_pick_idx;
                end
            end
            S_XFER: begin
                if (w_hs_last || w_force_release) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = w_after_g;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_INIT;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_credits <= c_CRED_MAX;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_credits <= w_credits_nxt;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TimeoutCycles + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TimeoutCycles - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_TO_W-1:0] w_to_nxt;
    logic              r_timeout;

    // Counts XFER cycles without a handshake; the count is zero whenever a
    // new grant starts because every exit from XFER clears it.
    always_comb begin
        w_to_nxt        = '0;
        w_force_release = 1'b0;
        if ((r_state == S_XFER) && !w_hs) begin
            if (r_to_cnt == c_TO_LAST) begin
                w_force_release = 1'b1;
            end else begin
                w_to_nxt = r_to_cnt + c_TO_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_nxt;
            r_timeout <= w_force_release;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_force_release = 1'b0;
    assign timeout_o       = 1'b0;
`endif

    assign grant_o   = r_grant;
    assign credits_o = r_credits;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter: directed vector table,
//             hand-written multi-cycle sequences, and randomized traffic
//             compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int         N    = 4;
    localparam int         DW   = 8;
    localparam int         BW   = 32;
    localparam int         FD   = 16;
    localparam int         TO   = 8;
    localparam logic [1:0] BAUD = 2'b10;
    localparam int         CW   = $clog2(FD + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid, last, ready, grant;
    logic [N*DW-1:0] data;
    logic            done, wr, tmo;
    logic [BW-1:0]   addr, wdata;
    logic [CW-1:0]   credits;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumReq(N), .UartDataWidth(DW), .BusDataWidth(BW), .FifoDepth(FD),
        .BaudSel(BAUD), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
        .req_ready_o(ready), .tx_done_i(done),
        .bus_wr_en_o(wr), .bus_addr_o(addr), .bus_wdata_o(wdata),
        .grant_o(grant), .credits_o(credits), .timeout_o(tmo)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // phase: 0 = baud write, 1 = waiting for a packet, 2 = packet owned
    int       m_phase = 0;
    int       m_cred  = FD;
    int       m_ptr   = 0;
    int       m_own   = 0;
    int       m_wait  = 0;
    bit       m_tpulse = 0;
    logic [N-1:0]  m_acc = '0;
    logic [N-1:0]  e_ready;
    bit            e_hs;
    logic          e_wr;
    logic [BW-1:0] e_addr, e_wdata;

    function automatic void model_eval();
        e_ready = '0; e_hs = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
        if (!rst) begin
            if (m_phase == 2 && m_cred > 0) begin
                e_ready = N'(1) << m_own;
                e_hs    = ((valid >> m_own) & N'(1)) != '0;
            end
            if (m_phase == 0) begin
                e_wr = 1; e_wdata = BW'(BAUD);
            end else if (e_hs) begin
                e_wr = 1; e_addr = 3;
                e_wdata = BW'((data >> (m_own * DW)) & {DW{1'b1}});
            end
        end
    endfunction

    function automatic void model_step();
        int  oc;
        bit  rel;
        bit  found;
        if (rst) begin
            m_phase = 0; m_cred = FD; m_ptr = 0; m_own = 0; m_wait = 0; m_tpulse = 0;
            return;
        end
        oc = m_cred;
        m_tpulse = 0;
        if (e_hs && !done) m_cred = oc - 1;
        else if (!e_hs && done && oc < FD) m_cred = oc + 1;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            found = 0;
            if (oc > 0) begin
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = (m_ptr + i) % N;
                    if (!found && (((valid >> j) & N'(1)) != '0)) begin
                        found = 1; m_own = j; m_phase = 2; m_wait = 0;
                    end
                end
            end
        end else begin
            rel = 0;
            if (e_hs) begin
                m_wait = 0;
                rel = ((last >> m_own) & N'(1)) != '0;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TO) begin rel = 1; m_tpulse = 1; m_wait = 0; end
            end
`endif
            if (rel) begin m_ptr = (m_own + 1) % N; m_phase = 1; end
        end
    endfunction

    task automatic cmp_model();
        chk("m_ready",   ready,   e_ready);
        chk("m_wr_en",   wr,      e_wr);
        chk("m_addr",    addr,    e_addr);
        chk("m_wdata",   wdata,   e_wdata);
        chk("m_grant",   grant,   (m_phase == 2) ? (N'(1) << m_own) : N'(0));
        chk("m_credits", credits, 64'(m_cred));
        chk("m_timeout", tmo,     m_tpulse);
    endtask

    // One clock cycle: settle, optional model compare, edge, model update.
    task automatic tick(input bit cmp);
        #1;
        model_eval();
        if (cmp) cmp_model();
        m_acc = e_hs ? (N'(1) << m_own) : '0;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input bit cmp);
        rst = 1; valid = '0; last = '0; data = '0; done = 0;
        tick(0);
        tick(cmp);
        rst = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        dn;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  g;
        logic [3:0]  rdy;
        int          cr;
    } vec_t;

    vec_t tbl[16];

    int rem[N];

    task automatic gen_random();
        for (int k = 0; k < N; k++) begin
            if (!(valid[k] && !m_acc[k])) begin
                valid[k] = 1'b0;
                last[k]  = 1'b0;
                if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = $urandom_range(1, 5);
                if (rem[k] > 0 && $urandom_range(0, 3) != 0) begin
                    valid[k]          = 1'b1;
                    data[k*DW +: DW]  = 8'($urandom);
                    last[k]           = (rem[k] == 1);
                    rem[k]--;
                end
            end
        end
        done = ($urandom_range(0, 2) == 0);
        rst  = ($urandom_range(0, 249) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  sent, writes, hs2, pulses, first;
        bit  acc, got;

        //        rst  v        d              l        dn   wr a   wd            g        rdy      cr
        tbl[0]  = '{1, 4'b0000, 32'h0000_0000, 4'b0000, 0,   0, 0, 32'h0,        4'b0000, 4'b0000, 16};
        tbl[1]  = '{0, 4'b0101, 32'h00C0_00A0, 4'b0000, 0,   1, 0, 32'h2,        4'b0000, 4'b0000, 16};
        tbl[2]  = '{0, 4'b0101, 32'h00C0_00A0, 4'b0000, 0,   0, 0, 32'h0,        4'b0000, 4'b0000, 16};
        tbl[3]  = '{0, 4'b0101, 32'h00C0_00A0, 4'b0000, 0,   1, 3, 32'hA0,       4'b0001, 4'b0001, 16};
        tbl[4]  = '{0, 4'b0101, 32'h00C0_00A1, 4'b0000, 0,   1, 3, 32'hA1,       4'b0001, 4'b0001, 15};
        tbl[5]  = '{0, 4'b0101, 32'h00C0_00A2, 4'b0001, 0,   1, 3, 32'hA2,       4'b0001, 4'b0001, 14};
        tbl[6]  = '{0, 4'b0100, 32'h00C0_0000, 4'b0000, 0,   0, 0, 32'h0,        4'b0000, 4'b0000, 13};
        tbl[7]  = '{0, 4'b0100, 32'h00C0_0000, 4'b0000, 1,   1, 3, 32'hC0,       4'b0100, 4'b0100, 13};
        tbl[8]  = '{0, 4'b0100, 32'h00C1_0000, 4'b0000, 0,   1, 3, 32'hC1,       4'b0100, 4'b0100, 13};
        tbl[9]  = '{0, 4'b0100, 32'h00C2_0000, 4'b0100, 0,   1, 3, 32'hC2,       4'b0100, 4'b0100, 12};
        tbl[10] = '{0, 4'b1001, 32'hD000_00E0, 4'b1001, 0,   0, 0, 32'h0,        4'b0000, 4'b0000, 11};
        tbl[11] = '{0, 4'b1001, 32'hD000_00E0, 4'b1001, 0,   1, 3, 32'hD0,       4'b1000, 4'b1000, 11};
        tbl[12] = '{0, 4'b0001, 32'h0000_00E0, 4'b0001, 0,   0, 0, 32'h0,        4'b0000, 4'b0000, 10};
        tbl[13] = '{0, 4'b0001, 32'h0000_00E0, 4'b0001, 1,   1, 3, 32'hE0,       4'b0001, 4'b0001, 10};
        tbl[14] = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 1,   0, 0, 32'h0,        4'b0000, 4'b0000, 10};
        tbl[15] = '{0, 4'b0000, 32'h0000_0000, 4'b0000, 0,   0, 0, 32'h0,        4'b0000, 4'b0000, 11};

        rst = 1; valid = '0; last = '0; data = '0; done = 0;
        tick(0);
        tick(0);

        for (int r = 0; r < 16; r++) begin
            rst = tbl[r].rst; valid = tbl[r].v; data = tbl[r].d; last = tbl[r].l; done = tbl[r].dn;
            #1;
            chk($sformatf("tbl%0d_wr", r),      wr,      tbl[r].wr);
            chk($sformatf("tbl%0d_addr", r),    addr,    tbl[r].a);
            chk($sformatf("tbl%0d_wdata", r),   wdata,   tbl[r].wd);
            chk($sformatf("tbl%0d_grant", r),   grant,   tbl[r].g);
            chk($sformatf("tbl%0d_ready", r),   ready,   tbl[r].rdy);
            chk($sformatf("tbl%0d_credits", r), credits, 64'(tbl[r].cr));
            tick(0);
        end

        // ---- credit exhaustion: req1 streams 20 bytes, no tx_done ----
        do_reset(1);
        sent = 0; writes = 0;
        valid[1] = 1'b1; data[15:8] = 8'h01;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin valid[0] = 1'b1; data[7:0] = 8'hEE; end
            #1;
            acc = ready[1] && valid[1];
            if (wr && addr == 32'd3) begin
                writes++;
                chk("stream_wdata", wdata, 64'(sent + 1));
            end
            tick(1);
            if (acc) begin
                sent++;
                if (sent == 20) begin valid[1] = 1'b0; last[1] = 1'b0; end
                else begin data[15:8] = 8'(sent + 1); last[1] = (sent == 19); end
            end
        end
        chk("stream_writes_16", writes, 16);
        chk("stream_ready_low", ready, 4'b0000);
        chk("stream_credits_0", credits, 0);
        chk("stream_grant_lock", grant, 4'b0010);
        done = 1;
        tick(1);
        done = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (wr && addr == 32'd3) writes++;
            tick(1);
        end
        chk("stream_one_more", writes, 17);

        // ---- reset in the middle of a packet ----
        do_reset(1);
        valid[0] = 1'b1; last[0] = 1'b1; data[7:0] = 8'h55;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            #1; got = ready[0] && valid[0];
            tick(1);
        end
        chk("midrst_req0_hs", got, 1);
        valid[0] = 1'b0; last[0] = 1'b0;
        valid[2] = 1'b1; last[2] = 1'b0; data[23:16] = 8'h60;
        hs2 = 0;
        for (int n = 0; n < 20 && hs2 < 2; n++) begin
            #1; acc = ready[2] && valid[2];
            tick(1);
            if (acc) begin hs2++; data[23:16] = data[23:16] + 8'h01; end
        end
        chk("midrst_two_bytes", hs2, 2);
        rst = 1;
        #1;
        chk("midrst_ready_in_rst", ready, 4'b0000);
        chk("midrst_wr_in_rst", wr, 0);
        tick(1);
        rst = 0; valid = 4'b0101; last = 4'b0101; data = 32'h0033_0022;
        #1;
        chk("midrst_init_wr", wr, 1);
        chk("midrst_init_addr", addr, 0);
        chk("midrst_init_wdata", wdata, 32'h2);
        chk("midrst_grant0", grant, 4'b0000);
        chk("midrst_credits16", credits, 16);
        tick(1);
        tick(1);
        #1;
        chk("midrst_req0_wins", grant, 4'b0001);
        tick(1);

        // ---- idle lock: granted req3 drops valid ----
        do_reset(1);
        valid = 4'b1000; last = 4'b0000; data = 32'hD300_0000;
        tick(1);
        tick(1);
        #1;
        chk("lock_req3_granted", grant, 4'b1000);
        chk("lock_req3_byte", wdata, 32'hD3);
        tick(1);
        valid = 4'b0000;
        pulses = 0; first = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (tmo) begin
                pulses++;
                if (first == 0) first = c;
            end
            tick(1);
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("timeout_cycle", first, 9);
        chk("timeout_pulses", pulses, 1);
        valid = 4'b1001; last = 4'b1001; data = 32'hD400_0044;
        tick(1);
        #1;
        chk("timeout_req0_next", grant, 4'b0001);
        tick(1);
`else
        chk("nolock_release_grant", grant, 4'b1000);
        chk("nolock_no_pulse", pulses, 0);
`endif

        // ---- randomized traffic against the model ----
        do_reset(1);
        for (int k = 0; k < N; k++) rem[k] = 0;
        m_acc = '0;
        for (int c = 0; c < 800; c++) begin
            gen_random();
            if (rst) begin
                for (int k = 0; k < N; k++) rem[k] = 0;
            end
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
